led_pattern_gen: RTL and testbench

Parametrised LED pattern generator: a prescaler counter derives a step tick from the system clock, and each tick advances an NB_LEDS-wide pattern in one of four modes (flash, rotate left, rotate right, ping-pong) at one of four run-time-selectable speeds. It sits between the board clock/reset/switch inputs and the LED pins. It succeeds the fixed 4-LED flash block and adds width, speed and mode parameters.

---
 rtl/led_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler derives a step tick that advances an
// NB_LEDS-wide pattern in flash, rotate-left, rotate-right or ping-pong mode.
module led_pattern_gen #(
    parameter int NB_LEDS  = 4,
    parameter int NB_COUNT = 32,
    parameter int LIMIT0   = 25_000_000,
    parameter int LIMIT1   = 12_500_000,
    parameter int LIMIT2   = 6_250_000,
    parameter int LIMIT3   = 3_125_000
) (
    input  logic               clk,
    input  logic               i_ck_rst,
    input  logic               i_enable,
    input  logic [1:0]         i_mode,
    input  logic [1:0]         i_speed,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_tick
);

    localparam logic [1:0] MODE_FLASH = 2'b00;
    localparam logic [1:0] MODE_ROT_L = 2'b01;
    localparam logic [1:0] MODE_ROT_R = 2'b10;
    localparam logic [1:0] MODE_PING  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [NB_COUNT-1:0] LIM0_M1    = NB_COUNT'(LIMIT0 - 1);
    localparam logic [NB_COUNT-1:0] LIM1_M1    = NB_COUNT'(LIMIT1 - 1);
    localparam logic [NB_COUNT-1:0] LIM2_M1    = NB_COUNT'(LIMIT2 - 1);
    localparam logic [NB_COUNT-1:0] LIM3_M1    = NB_COUNT'(LIMIT3 - 1);
    localparam logic [NB_COUNT-1:0] COUNT_ZERO = {NB_COUNT{1'b0}};
    localparam logic [NB_COUNT-1:0] COUNT_ONE  = {{(NB_COUNT-1){1'b0}}, 1'b1};

    localparam logic [NB_LEDS-1:0] LED_ZERO    = {NB_LEDS{1'b0}};
    localparam logic [NB_LEDS-1:0] ONE_HOT_LSB = {{(NB_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_LEDS-1:0] ONE_HOT_MSB = {1'b1, {(NB_LEDS-1){1'b0}}};

    function automatic logic [NB_LEDS-1:0] seed_of(input logic [1:0] mode);
        logic [NB_LEDS-1:0] seed;
        case (mode)
            MODE_FLASH: seed = LED_ZERO;
            MODE_ROT_L: seed = ONE_HOT_LSB;
            MODE_ROT_R: seed = ONE_HOT_MSB;
            MODE_PING:  seed = ONE_HOT_LSB;
            default:    seed = LED_ZERO;
        endcase
        return seed;
    endfunction

    logic [NB_COUNT-1:0] count_r;
    logic [1:0]          mode_r;
    logic                dir_r;
    logic [NB_LEDS-1:0]  led_r;
    logic                tick_r;

    logic [NB_COUNT-1:0] count_s;
    logic [1:0]          mode_s;
    logic                dir_s;
    logic [NB_LEDS-1:0]  led_s;
    logic                tick_s;
    logic [NB_COUNT-1:0] lim_m1_s;
    logic [NB_LEDS-1:0]  step_led_s;
    logic                step_dir_s;

    // State register: prescaler, stored mode, ping-pong direction and outputs.
    always_ff @(posedge clk or negedge i_ck_rst) begin
        if (!i_ck_rst) begin
            count_r <= COUNT_ZERO;
            mode_r  <= MODE_FLASH;
            dir_r   <= DIR_LEFT;
            led_r   <= LED_ZERO;
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_s;
            mode_r  <= mode_s;
            dir_r   <= dir_s;
            led_r   <= led_s;
            tick_r  <= tick_s;
        end
    end

    // Terminal count for the currently selected speed.
    always_comb begin
        lim_m1_s = LIM0_M1;
        case (i_speed)
            2'b00:   lim_m1_s = LIM0_M1;
            2'b01:   lim_m1_s = LIM1_M1;
            2'b10:   lim_m1_s = LIM2_M1;
            2'b11:   lim_m1_s = LIM3_M1;
            default: lim_m1_s = LIM0_M1;
        endcase
    end

    // Pattern the LEDs would take on a step; an empty pattern reseeds.
    always_comb begin
        step_led_s = led_r;
        step_dir_s = dir_r;
        if ((mode_r != MODE_FLASH) && (led_r == LED_ZERO)) begin
            step_led_s = seed_of(mode_r);
            step_dir_s = DIR_LEFT;
        end else begin
            case (mode_r)
                MODE_FLASH: step_led_s = ~led_r;
                MODE_ROT_L: step_led_s = {led_r[NB_LEDS-2:0], led_r[NB_LEDS-1]};
                MODE_ROT_R: step_led_s = {led_r[0], led_r[NB_LEDS-1:1]};
                MODE_PING: begin
                    // Bounce off an end LED so it stays lit for one step only.
                    if ((dir_r == DIR_LEFT) && led_r[NB_LEDS-1]) begin
                        step_led_s = led_r >> 1;
                        step_dir_s = DIR_RIGHT;
                    end else if ((dir_r == DIR_RIGHT) && led_r[0]) begin
                        step_led_s = led_r << 1;
                        step_dir_s = DIR_LEFT;
                    end else if (dir_r == DIR_LEFT) begin
                        step_led_s = led_r << 1;
                        step_dir_s = DIR_LEFT;
                    end else begin
                        step_led_s = led_r >> 1;
                        step_dir_s = DIR_RIGHT;
                    end
                end
                default: step_led_s = led_r;
            endcase
        end
    end

    // Next state: a mode change outranks a coincident step.
    always_comb begin
        count_s = count_r;
        mode_s  = mode_r;
        dir_s   = dir_r;
        led_s   = led_r;
        tick_s  = 1'b0;
        if (i_mode != mode_r) begin
            mode_s  = i_mode;
            count_s = COUNT_ZERO;
            led_s   = seed_of(i_mode);
            dir_s   = DIR_LEFT;
        end else if (i_enable) begin
            if (count_r >= lim_m1_s) begin
                count_s = COUNT_ZERO;
                led_s   = step_led_s;
                dir_s   = step_dir_s;
                tick_s  = 1'b1;
            end else begin
                count_s = count_r + COUNT_ONE;
            end
        end else begin
            count_s = count_r;
        end
    end

    assign o_led  = led_r;
    assign o_tick = tick_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed vector table, corner-case
// sequences and random stimulus against a position/arithmetic reference model.
module tb_led_pattern_gen;

    localparam int N = 4;

    logic       clk;
    logic       i_ck_rst;
    logic       i_enable;
    logic [1:0] i_mode;
    logic [1:0] i_speed;
    logic [3:0] o_led;
    logic       o_tick;

    int total = 0;
    int bad   = 0;

    led_pattern_gen #(
        .NB_LEDS (N),
        .NB_COUNT(8),
        .LIMIT0  (4),
        .LIMIT1  (8),
        .LIMIT2  (16),
        .LIMIT3  (32)
    ) dut (
        .clk     (clk),
        .i_ck_rst(i_ck_rst),
        .i_enable(i_enable),
        .i_mode  (i_mode),
        .i_speed (i_speed),
        .o_led   (o_led),
        .o_tick  (o_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [1:0] spd;
        logic [3:0] led;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    // Reference model: counter as an integer, ping-pong as a lit position.
    int         m_count;
    logic [1:0] m_mode;
    logic [3:0] m_led;
    logic       m_tick;
    int         m_pos;
    int         m_dir;

    logic [3:0] pp_exp [7];
    logic [3:0] snap;

    function automatic int lim_of(input logic [1:0] s);
        case (s)
            2'd0:    return 4;
            2'd1:    return 8;
            2'd2:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic void add(input logic en, input logic [1:0] mode, input logic [1:0] spd,
                                input logic [3:0] led, input logic tick);
        vec_t v;
        v.en = en; v.mode = mode; v.spd = spd; v.led = led; v.tick = tick;
        vecs.push_back(v);
    endfunction

    task automatic model_reset();
        m_count = 0; m_mode = 2'd0; m_led = 4'd0; m_tick = 1'b0; m_pos = 0; m_dir = 1;
    endtask

    task automatic model_advance();
        int v;
        v = int'(m_led);
        case (m_mode)
            2'd0: m_led = ~m_led;
            2'd1: m_led = 4'((v * 2) % 16 + v / 8);
            2'd2: m_led = 4'(v / 2 + (v % 2) * 8);
            default: begin
                if (m_pos == N - 1 && m_dir == 1) m_dir = -1;
                else if (m_pos == 0 && m_dir == -1) m_dir = 1;
                m_pos = m_pos + m_dir;
                m_led = 4'(1 << m_pos);
            end
        endcase
    endtask

    task automatic model_edge();
        if (!i_ck_rst) begin
            model_reset();
        end else begin
            m_tick = 1'b0;
            if (i_mode != m_mode) begin
                m_mode = i_mode; m_count = 0; m_pos = 0; m_dir = 1;
                case (i_mode)
                    2'd0:    m_led = 4'b0000;
                    2'd2:    m_led = 4'b1000;
                    default: m_led = 4'b0001;
                endcase
            end else if (i_enable) begin
                if (m_count >= lim_of(i_speed) - 1) begin
                    m_count = 0;
                    m_tick  = 1'b1;
                    model_advance();
                end else begin
                    m_count = m_count + 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cmp_model(input string nm);
        chk({nm, "_led"}, 32'(o_led), 32'(m_led));
        chk({nm, "_tick"}, 32'(o_tick), 32'(m_tick));
    endtask

    // Called just after an edge; pulses reset between edges.
    task automatic async_reset();
        #1 i_ck_rst = 1'b0;
        #1;
        chk("areset_led", 32'(o_led), 32'd0);
        chk("areset_tick", 32'(o_tick), 32'd0);
        model_reset();
        #1 i_ck_rst = 1'b1;
    endtask

    initial begin
        i_ck_rst = 1'b0; i_enable = 1'b1; i_mode = 2'd0; i_speed = 2'd0;
        model_reset();
        pp_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        @(posedge clk);
        #1;
        chk("reset_led", 32'(o_led), 32'd0);
        chk("reset_tick", 32'(o_tick), 32'd0);
        i_ck_rst = 1'b1;

        // Flash, then rotate left, then rotate right (one entry per edge).
        add(1, 0, 0, 4'b0000, 0); add(1, 0, 0, 4'b0000, 0); add(1, 0, 0, 4'b0000, 0);
        add(1, 0, 0, 4'b1111, 1); add(1, 0, 0, 4'b1111, 0); add(1, 0, 0, 4'b1111, 0);
        add(1, 0, 0, 4'b1111, 0); add(1, 0, 0, 4'b0000, 1);
        add(1, 1, 0, 4'b0001, 0); add(1, 1, 0, 4'b0001, 0); add(1, 1, 0, 4'b0001, 0);
        add(1, 1, 0, 4'b0001, 0); add(1, 1, 0, 4'b0010, 1); add(1, 1, 0, 4'b0010, 0);
        add(1, 1, 0, 4'b0010, 0); add(1, 1, 0, 4'b0010, 0); add(1, 1, 0, 4'b0100, 1);
        add(1, 2, 0, 4'b1000, 0); add(1, 2, 0, 4'b1000, 0); add(1, 2, 0, 4'b1000, 0);
        add(1, 2, 0, 4'b1000, 0); add(1, 2, 0, 4'b0100, 1);
        foreach (vecs[i]) begin
            i_enable = vecs[i].en; i_mode = vecs[i].mode; i_speed = vecs[i].spd;
            cycle();
            chk("vec_led", 32'(o_led), 32'(vecs[i].led));
            chk("vec_tick", 32'(o_tick), 32'(vecs[i].tick));
        end

        // Ping-pong sweep.
        i_mode = 2'd3;
        cycle();
        chk("pp_seed_led", 32'(o_led), 32'b0001);
        chk("pp_seed_tick", 32'(o_tick), 32'd0);
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < 4; c++) begin
                cycle();
                cmp_model("pp");
            end
            chk("pp_step_led", 32'(o_led), 32'(pp_exp[k]));
            chk("pp_step_tick", 32'(o_tick), 32'd1);
        end

        // Enable hold: freeze after two counts, resume two edges from the step.
        cycle(); cycle();
        i_enable = 1'b0;
        snap = o_led;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("hold_led", 32'(o_led), 32'(snap));
            chk("hold_tick", 32'(o_tick), 32'd0);
        end
        i_enable = 1'b1;
        cycle();
        chk("reen_first_tick", 32'(o_tick), 32'd0);
        cycle();
        chk("reen_step_tick", 32'(o_tick), 32'd1);
        chk("reen_step_led", 32'(o_led), 32'b0100);

        // Speed lowered with the counter above the new limit.
        i_speed = 2'd3;
        for (int c = 0; c < 20; c++) begin
            cycle();
            cmp_model("slow");
        end
        i_speed = 2'd0;
        cycle();
        chk("spd_wrap_tick", 32'(o_tick), 32'd1);
        chk("spd_wrap_led", 32'(o_led), 32'b1000);
        for (int c = 0; c < 4; c++) begin
            cycle();
            cmp_model("spd_after");
        end
        chk("spd_next_led", 32'(o_led), 32'b0100);

        // Asynchronous reset mid-pattern, then seed load on first edge.
        i_mode = 2'd1;
        cycle();
        for (int c = 0; c < 8; c++) begin
            cycle();
            cmp_model("pre_rst");
        end
        chk("pre_rst_led", 32'(o_led), 32'b0100);
        async_reset();
        cycle();
        chk("post_rst_led", 32'(o_led), 32'b0001);
        chk("post_rst_tick", 32'(o_tick), 32'd0);

        // Mode change on the edge that would otherwise step.
        cycle(); cycle(); cycle();
        i_mode = 2'd2;
        cycle();
        chk("coinc_led", 32'(o_led), 32'b1000);
        chk("coinc_tick", 32'(o_tick), 32'd0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("coinc_wait_tick", 32'(o_tick), 32'd0);
        end
        cycle();
        chk("coinc_next_tick", 32'(o_tick), 32'd1);
        chk("coinc_next_led", 32'(o_led), 32'b0100);

        // Random stimulus against the model.
        for (int c = 0; c < 500; c++) begin
            i_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) i_speed = 2'($urandom_range(0, 3));
            cycle();
            cmp_model("rand");
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
